// File: rtl/axmul_mac_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : axmul_mac_seq_if
//  Brief    : Operand, multiplier and result signal bundle for axmul_mac_seq.
//             err_acc_o exists only when AXMUL_ERR_TRACK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface axmul_mac_seq_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             start_i;
    logic [CNT_W-1:0] len_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [7:0]       in_a_i;
    logic [7:0]       in_b_i;
    logic [7:0]       mul_a_o;
    logic [7:0]       mul_b_o;
    logic [15:0]      mul_p_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [ACC_W-1:0] res_acc_o;
    logic             res_ovf_o;
    logic             busy_o;
`ifdef AXMUL_ERR_TRACK_EN
    logic [ACC_W-1:0] err_acc_o;
`endif

    // Slave side is the MAC sequencer; master side is the surrounding system.
    modport slave (
        input  start_i, len_i, in_valid_i, in_a_i, in_b_i, mul_p_i, res_ready_i,
`ifdef AXMUL_ERR_TRACK_EN
        output err_acc_o,
`endif
        output in_ready_o, mul_a_o, mul_b_o, res_valid_o, res_acc_o, res_ovf_o, busy_o
    );

    modport master (
        output start_i, len_i, in_valid_i, in_a_i, in_b_i, mul_p_i, res_ready_i,
`ifdef AXMUL_ERR_TRACK_EN
        input  err_acc_o,
`endif
        input  in_ready_o, mul_a_o, mul_b_o, res_valid_o, res_acc_o, res_ovf_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/axmul_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : axmul_mac_seq
//  Brief    : Multiply-accumulate sequencer wrapped around the 8x8 approximate
//             multiplier. Optional macro AXMUL_ERR_TRACK_EN adds an
//             approximation-error accumulator (err_acc_o).
//  Revision : 1.0  initial release
// ============================================================================
module axmul_mac_seq #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  wire logic         wb_clk_i,
    input  wire logic         wb_rst_ni,
    axmul_mac_seq_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FEED = 3'd1,
        S_MUL  = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [7:0]       r_mul_a;
    logic [7:0]       r_mul_b;
    logic [15:0]      r_prod;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W:0]   w_sum;
    logic             w_start;
    logic             w_fire;

    assign w_start   = (r_state == S_IDLE) && bus.start_i;
    assign w_fire    = (r_state == S_FEED) && bus.in_valid_i;
    assign w_cnt_inc = r_cnt + 1'b1;
    // Extra top bit captures the carry-out that drives the sticky overflow.
    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(r_prod);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start_i) w_state_nxt = (bus.len_i == '0) ? S_DONE : S_FEED;
            S_FEED: if (bus.in_valid_i) w_state_nxt = S_MUL;
            S_MUL:  w_state_nxt = S_ACC;
            S_ACC:  w_state_nxt = (w_cnt_inc == r_len) ? S_DONE : S_FEED;
            S_DONE: if (bus.res_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_start) begin
                r_len <= bus.len_i;
                r_cnt <= '0;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end
            // Operand registers deliberately keep their value between pairs.
            if (w_fire) begin
                r_mul_a <= bus.in_a_i;
                r_mul_b <= bus.in_b_i;
            end
            if (r_state == S_MUL) r_prod <= bus.mul_p_i;
            if (r_state == S_ACC) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ovf <= r_ovf | w_sum[ACC_W];
                r_cnt <= w_cnt_inc;
            end
        end
    end

`ifdef AXMUL_ERR_TRACK_EN
    logic [15:0]      r_exact;
    logic [15:0]      w_diff;
    logic [ACC_W:0]   w_err_sum;
    logic [ACC_W-1:0] r_err;

    assign w_diff    = (r_exact >= r_prod) ? (r_exact - r_prod) : (r_prod - r_exact);
    assign w_err_sum = {1'b0, r_err} + (ACC_W+1)'(w_diff);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_exact <= '0;
            r_err   <= '0;
        end else begin
            if (w_start) r_err <= '0;
            if (r_state == S_MUL) r_exact <= 16'(r_mul_a) * 16'(r_mul_b);
            // Saturate rather than wrap so a large error never looks small.
            if (r_state == S_ACC) r_err <= w_err_sum[ACC_W] ? '1 : w_err_sum[ACC_W-1:0];
        end
    end

    assign bus.err_acc_o = r_err;
`endif

    assign bus.in_ready_o  = (r_state == S_FEED);
    assign bus.res_valid_o = (r_state == S_DONE);
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.mul_a_o     = r_mul_a;
    assign bus.mul_b_o     = r_mul_b;
    assign bus.res_acc_o   = r_acc;
    assign bus.res_ovf_o   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_axmul_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axmul_mac_seq
//  Brief    : Directed self-checking bench; a 24-bit and a 16-bit accumulator
//             instance see identical stimulus. AXMUL_ERR_TRACK_EN enables the
//             error-accumulator step.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axmul_mac_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        force_en;
    logic [15:0] force_p;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    axmul_mac_seq_if #(.ACC_W(24), .CNT_W(8)) b24 ();
    axmul_mac_seq_if #(.ACC_W(16), .CNT_W(8)) b16 ();

    axmul_mac_seq #(.ACC_W(24), .CNT_W(8)) dut24 (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(b24));
    axmul_mac_seq #(.ACC_W(16), .CNT_W(8)) dut16 (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(b16));

    // Exact multiplier model, optionally overridden to mimic an approximate product.
    assign b24.mul_p_i = force_en ? force_p : 16'(b24.mul_a_o) * 16'(b24.mul_b_o);
    assign b16.mul_p_i = 16'(b16.mul_a_o) * 16'(b16.mul_b_o);

    assign b16.start_i     = b24.start_i;
    assign b16.len_i       = b24.len_i;
    assign b16.in_valid_i  = b24.in_valid_i;
    assign b16.in_a_i      = b24.in_a_i;
    assign b16.in_b_i      = b24.in_b_i;
    assign b16.res_ready_i = b24.res_ready_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] len);
        b24.start_i = 1'b1;
        b24.len_i   = len;
        @(negedge clk);
        b24.start_i = 1'b0;
    endtask

    // Returns at the negedge just after the handshake edge (DUT then in MUL).
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 20 && !b24.in_ready_o; i++) @(negedge clk);
        chk("feed_wait", 32'(b24.in_ready_o), 32'd1);
        b24.in_valid_i = 1'b1;
        b24.in_a_i     = a;
        b24.in_b_i     = b;
        @(negedge clk);
        b24.in_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        force_en = 1'b0;
        force_p  = 16'd0;
        b24.start_i = 1'b0;
        b24.len_i = 8'd0;
        b24.in_valid_i = 1'b0;
        b24.in_a_i = 8'd0;
        b24.in_b_i = 8'd0;
        b24.res_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(b24.busy_o), 32'd0);
        chk("rst_valid", 32'(b24.res_valid_o), 32'd0);
        chk("rst_ready", 32'(b24.in_ready_o), 32'd0);
        chk("rst_acc",   32'(b24.res_acc_o), 32'd0);
        chk("rst_mul_a", 32'(b24.mul_a_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(b24.busy_o), 32'd0);

        // Three-pair job: 15 + 14 + 100.
        start_job(8'd3);
        chk("t1_feed_ready", 32'(b24.in_ready_o), 32'd1);
        chk("t1_feed_busy",  32'(b24.busy_o), 32'd1);
        send_pair(8'd3, 8'd5);
        chk("t1_mul_ready", 32'(b24.in_ready_o), 32'd0);
        chk("t1_mul_a", 32'(b24.mul_a_o), 32'd3);
        send_pair(8'd2, 8'd7);
        send_pair(8'd10, 8'd10);
        chk("t1_valid_t1", 32'(b24.res_valid_o), 32'd0);
        @(negedge clk);
        chk("t1_valid_t2", 32'(b24.res_valid_o), 32'd0);
        @(negedge clk);
        chk("t1_valid_t3", 32'(b24.res_valid_o), 32'd1);
        chk("t1_acc", 32'(b24.res_acc_o), 32'd129);
        chk("t1_ovf", 32'(b24.res_ovf_o), 32'd0);
        @(negedge clk);
        chk("t1_drop_valid", 32'(b24.res_valid_o), 32'd0);
        chk("t1_idle_busy",  32'(b24.busy_o), 32'd0);

        // Empty job goes straight to DONE with a cleared accumulator.
        start_job(8'd0);
        chk("t2_valid", 32'(b24.res_valid_o), 32'd1);
        chk("t2_acc",   32'(b24.res_acc_o), 32'd0);
        chk("t2_ready", 32'(b24.in_ready_o), 32'd0);
        @(negedge clk);
        chk("t2_drop_valid", 32'(b24.res_valid_o), 32'd0);
        chk("t2_ready_idle", 32'(b24.in_ready_o), 32'd0);

        // Result back-pressure: hold, ignore start pulses.
        b24.res_ready_i = 1'b0;
        start_job(8'd3);
        send_pair(8'd3, 8'd5);
        send_pair(8'd2, 8'd7);
        send_pair(8'd10, 8'd10);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(b24.res_valid_o), 32'd1);
            chk("t3_hold_acc",   32'(b24.res_acc_o), 32'd129);
            chk("t3_hold_ready", 32'(b24.in_ready_o), 32'd0);
            b24.start_i = 1'b1;
            b24.len_i   = 8'd0;
            @(negedge clk);
        end
        b24.start_i = 1'b0;
        chk("t3_after_start_acc", 32'(b24.res_acc_o), 32'd129);
        b24.res_ready_i = 1'b1;
        @(negedge clk);
        chk("t3_release", 32'(b24.res_valid_o), 32'd0);

        // Overflow: 2 x 65025 = 130050.
        start_job(8'd2);
        send_pair(8'd255, 8'd255);
        send_pair(8'd255, 8'd255);
        repeat (2) @(negedge clk);
        chk("t4_valid16", 32'(b16.res_valid_o), 32'd1);
        chk("t4_acc16",   32'(b16.res_acc_o), 32'd64514);
        chk("t4_ovf16",   32'(b16.res_ovf_o), 32'd1);
        chk("t4_acc24",   32'(b24.res_acc_o), 32'd130050);
        chk("t4_ovf24",   32'(b24.res_ovf_o), 32'd0);
        @(negedge clk);

        // Asynchronous reset mid-job.
        start_job(8'd3);
        send_pair(8'd9, 8'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy",  32'(b24.busy_o), 32'd0);
        chk("t5_mul_a", 32'(b24.mul_a_o), 32'd0);
        chk("t5_mul_b", 32'(b24.mul_b_o), 32'd0);
        chk("t5_acc",   32'(b24.res_acc_o), 32'd0);
        chk("t5_ovf16", 32'(b16.res_ovf_o), 32'd0);
        chk("t5_valid", 32'(b24.res_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_no_resume", 32'(b24.busy_o), 32'd0);
        start_job(8'd1);
        send_pair(8'd4, 8'd4);
        repeat (2) @(negedge clk);
        chk("t5_new_valid", 32'(b24.res_valid_o), 32'd1);
        chk("t5_new_acc",   32'(b24.res_acc_o), 32'd16);
        @(negedge clk);

`ifdef AXMUL_ERR_TRACK_EN
        // Approximate product 404 against exact 400.
        force_en = 1'b1;
        force_p  = 16'd404;
        start_job(8'd1);
        send_pair(8'd20, 8'd20);
        repeat (2) @(negedge clk);
        chk("t6_acc", 32'(b24.res_acc_o), 32'd404);
        chk("t6_err", 32'(b24.err_acc_o), 32'd4);
        force_en = 1'b0;
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
